// File: rtl/uart_core_param.sv
// uart_core_param: parametrised single-clock UART core.
// TX uses a valid/ready handshake. RX has a 2-flop synchroniser and reports
// parity and framing errors. Bit and sample timing come from clock enables
// derived from clk; no logic runs on a derived clock.
// Optional feature: define UART_LOOPBACK_EN to add the i_Loopback port, which
// routes the internal TX line into the RX synchroniser and holds o_Tx_Serial high.
module uart_core_param #(
  parameter int CLOCK_RATE    = 25000000,
  parameter int BAUD_RATE     = 115200,
  parameter int RX_OVERSAMPLE = 16,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef UART_LOOPBACK_EN
  input  logic                 i_Loopback,
`endif
  input  logic [DATA_BITS-1:0] i_Tx_Data,
  input  logic                 i_Tx_Valid,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Active,
  input  logic                 i_Rx_Serial,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Rx_Valid,
  output logic                 o_Rx_Parity_Err,
  output logic                 o_Rx_Frame_Err,
  output logic                 o_Rx_Busy
);

  localparam int BIT_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int SMP_DIV = CLOCK_RATE / (BAUD_RATE * RX_OVERSAMPLE);
  localparam int BIT_W   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int SMP_W   = (SMP_DIV > 1) ? $clog2(SMP_DIV) : 1;
  localparam int OVS_W   = $clog2(RX_OVERSAMPLE);

  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BIT_DIV - 1);
  localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'(SMP_DIV - 1);
  localparam logic [OVS_W-1:0] OVS_LAST  = OVS_W'(RX_OVERSAMPLE - 1);
  localparam logic [OVS_W-1:0] OVS_HALF  = OVS_W'(RX_OVERSAMPLE / 2 - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_t;

  // Parity bit that completes the configured odd/even weight of a word.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    if (PARITY == 1) begin
      parity_bit = ~(^d);
    end else begin
      parity_bit = ^d;
    end
  endfunction

  tx_state_t            tx_state_r;
  logic [BIT_W-1:0]     tx_div_r;
  logic [3:0]           tx_bit_r;
  logic [DATA_BITS-1:0] tx_shift_r;
  logic                 tx_par_r;
  logic                 tx_serial_r;
  logic                 tx_ready_r;
  logic                 tx_active_r;

  rx_state_t            rx_state_r;
  logic [SMP_W-1:0]     smp_cnt_r;
  logic                 smp_tick_r;
  logic                 rx_meta_r;
  logic                 rx_sync_r;
  logic [OVS_W-1:0]     rx_tick_r;
  logic [3:0]           rx_bit_r;
  logic [DATA_BITS-1:0] rx_shift_r;
  logic                 rx_par_r;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r;
  logic                 rx_perr_r;
  logic                 rx_ferr_r;
  logic                 rx_busy_r;
  logic                 rx_src_s;

`ifdef UART_LOOPBACK_EN
  assign rx_src_s    = i_Loopback ? tx_serial_r : i_Rx_Serial;
  assign o_Tx_Serial = i_Loopback ? 1'b1 : tx_serial_r;
`else
  assign rx_src_s    = i_Rx_Serial;
  assign o_Tx_Serial = tx_serial_r;
`endif

  assign o_Tx_Ready      = tx_ready_r;
  assign o_Tx_Active     = tx_active_r;
  assign o_Rx_Data       = rx_data_r;
  assign o_Rx_Valid      = rx_valid_r;
  assign o_Rx_Parity_Err = rx_perr_r;
  assign o_Rx_Frame_Err  = rx_ferr_r;
  assign o_Rx_Busy       = rx_busy_r;

  // TX FSM: accepts a word, then shifts start, data, parity and stop bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_r  <= TX_IDLE;
      tx_div_r    <= '0;
      tx_bit_r    <= 4'd0;
      tx_shift_r  <= '0;
      tx_par_r    <= 1'b0;
      tx_serial_r <= 1'b1;
      tx_ready_r  <= 1'b1;
      tx_active_r <= 1'b0;
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          if (i_Tx_Valid && tx_ready_r) begin
            tx_state_r  <= TX_START;
            tx_div_r    <= '0;
            tx_bit_r    <= 4'd0;
            tx_shift_r  <= i_Tx_Data;
            tx_par_r    <= parity_bit(i_Tx_Data);
            tx_serial_r <= 1'b0;
            tx_ready_r  <= 1'b0;
            tx_active_r <= 1'b1;
          end else begin
            // Ready comes back one cycle after the last stop bit ends.
            tx_ready_r <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_div_r == BIT_LAST) begin
            tx_div_r    <= '0;
            tx_state_r  <= TX_DATA;
            tx_serial_r <= tx_shift_r[0];
          end else begin
            tx_div_r <= tx_div_r + BIT_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_div_r == BIT_LAST) begin
            tx_div_r <= '0;
            if (tx_bit_r == DATA_LAST) begin
              tx_bit_r <= 4'd0;
              if (PARITY != 0) begin
                tx_state_r  <= TX_PARITY;
                tx_serial_r <= tx_par_r;
              end else begin
                tx_state_r  <= TX_STOP;
                tx_serial_r <= 1'b1;
              end
            end else begin
              tx_bit_r    <= tx_bit_r + 4'd1;
              tx_shift_r  <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
              tx_serial_r <= tx_shift_r[1];
            end
          end else begin
            tx_div_r <= tx_div_r + BIT_W'(1);
          end
        end
        TX_PARITY: begin
          if (tx_div_r == BIT_LAST) begin
            tx_div_r    <= '0;
            tx_state_r  <= TX_STOP;
            tx_serial_r <= 1'b1;
          end else begin
            tx_div_r <= tx_div_r + BIT_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_div_r == BIT_LAST) begin
            tx_div_r <= '0;
            if (tx_bit_r == STOP_LAST) begin
              tx_state_r  <= TX_IDLE;
              tx_active_r <= 1'b0;
              tx_bit_r    <= 4'd0;
            end else begin
              tx_bit_r <= tx_bit_r + 4'd1;
            end
            tx_serial_r <= 1'b1;
          end else begin
            tx_div_r <= tx_div_r + BIT_W'(1);
          end
        end
        default: begin
          tx_state_r  <= TX_IDLE;
          tx_serial_r <= 1'b1;
          tx_active_r <= 1'b0;
          tx_ready_r  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running RX sample tick, one pulse every SMP_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      smp_cnt_r  <= '0;
      smp_tick_r <= 1'b0;
    end else if (smp_cnt_r == SMP_LAST) begin
      smp_cnt_r  <= '0;
      smp_tick_r <= 1'b1;
    end else begin
      smp_cnt_r  <= smp_cnt_r + SMP_W'(1);
      smp_tick_r <= 1'b0;
    end
  end

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_src_s;
      rx_sync_r <= rx_meta_r;
    end
  end

  // RX FSM: start validation at half a bit, then centre sampling of each bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_r <= RX_IDLE;
      rx_tick_r  <= '0;
      rx_bit_r   <= 4'd0;
      rx_shift_r <= '0;
      rx_par_r   <= 1'b0;
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      rx_perr_r  <= 1'b0;
      rx_ferr_r  <= 1'b0;
      rx_busy_r  <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          if (!rx_sync_r) begin
            rx_state_r <= RX_START;
            rx_busy_r  <= 1'b1;
            rx_tick_r  <= '0;
          end
        end
        RX_START: begin
          if (smp_tick_r) begin
            if (rx_tick_r == OVS_HALF) begin
              rx_tick_r <= '0;
              rx_bit_r  <= 4'd0;
              if (rx_sync_r) begin
                // Line went back high: a glitch, not a start bit.
                rx_state_r <= RX_IDLE;
                rx_busy_r  <= 1'b0;
              end else begin
                rx_state_r <= RX_DATA;
              end
            end else begin
              rx_tick_r <= rx_tick_r + OVS_W'(1);
            end
          end
        end
        RX_DATA: begin
          if (smp_tick_r) begin
            if (rx_tick_r == OVS_LAST) begin
              rx_tick_r  <= '0;
              rx_shift_r <= {rx_sync_r, rx_shift_r[DATA_BITS-1:1]};
              if (rx_bit_r == DATA_LAST) begin
                rx_bit_r   <= 4'd0;
                rx_state_r <= (PARITY != 0) ? RX_PARITY : RX_STOP;
              end else begin
                rx_bit_r <= rx_bit_r + 4'd1;
              end
            end else begin
              rx_tick_r <= rx_tick_r + OVS_W'(1);
            end
          end
        end
        RX_PARITY: begin
          if (smp_tick_r) begin
            if (rx_tick_r == OVS_LAST) begin
              rx_tick_r  <= '0;
              rx_par_r   <= rx_sync_r;
              rx_state_r <= RX_STOP;
            end else begin
              rx_tick_r <= rx_tick_r + OVS_W'(1);
            end
          end
        end
        RX_STOP: begin
          if (smp_tick_r) begin
            if (rx_tick_r == OVS_LAST) begin
              rx_tick_r  <= '0;
              rx_valid_r <= 1'b1;
              rx_data_r  <= rx_shift_r;
              rx_perr_r  <= (PARITY != 0) && (rx_par_r != parity_bit(rx_shift_r));
              rx_ferr_r  <= ~rx_sync_r;
              rx_busy_r  <= 1'b0;
              // A low stop bit means a break: wait for the line to recover.
              rx_state_r <= rx_sync_r ? RX_IDLE : RX_BREAK;
            end else begin
              rx_tick_r <= rx_tick_r + OVS_W'(1);
            end
          end
        end
        RX_BREAK: begin
          if (rx_sync_r) begin
            rx_state_r <= RX_IDLE;
          end
        end
        default: begin
          rx_state_r <= RX_IDLE;
          rx_busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: two instances (8-bit odd parity 1 stop for RX,
// 7-bit even parity 2 stop for TX), a cycle-level frame model and an RX
// expectation queue, plus hand-computed literal expectations.
module tb_uart_core_param;
  localparam int CR = 1600000;
  localparam int BR = 100000;
  localparam int OS = 8;
  localparam int BD = CR / BR;  // 16 cycles per bit

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

`ifdef UART_LOOPBACK_EN
  logic lb = 1'b0;
`endif

  // Instance A: RX tests
  logic [7:0] a_tx_data = 8'h00;
  logic       a_tx_valid = 1'b0;
  logic       a_tx_ready, a_tx_serial, a_tx_active;
  logic       a_rx_serial = 1'b1;
  logic [7:0] a_rx_data;
  logic       a_rx_valid, a_pe, a_fe, a_busy;

  // Instance B: TX tests
  logic [6:0] b_tx_data = 7'h00;
  logic       b_tx_valid = 1'b0;
  logic       b_tx_ready, b_tx_serial, b_tx_active;
  logic       b_rx_serial = 1'b1;
  logic [6:0] b_rx_data;
  logic       b_rx_valid, b_pe, b_fe, b_busy;

  uart_core_param #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .RX_OVERSAMPLE(OS),
                    .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset),
`ifdef UART_LOOPBACK_EN
    .i_Loopback(lb),
`endif
    .i_Tx_Data(a_tx_data), .i_Tx_Valid(a_tx_valid), .o_Tx_Ready(a_tx_ready),
    .o_Tx_Serial(a_tx_serial), .o_Tx_Active(a_tx_active), .i_Rx_Serial(a_rx_serial),
    .o_Rx_Data(a_rx_data), .o_Rx_Valid(a_rx_valid), .o_Rx_Parity_Err(a_pe),
    .o_Rx_Frame_Err(a_fe), .o_Rx_Busy(a_busy));

  uart_core_param #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .RX_OVERSAMPLE(OS),
                    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset),
`ifdef UART_LOOPBACK_EN
    .i_Loopback(lb),
`endif
    .i_Tx_Data(b_tx_data), .i_Tx_Valid(b_tx_valid), .o_Tx_Ready(b_tx_ready),
    .o_Tx_Serial(b_tx_serial), .o_Tx_Active(b_tx_active), .i_Rx_Serial(b_rx_serial),
    .o_Rx_Data(b_rx_data), .o_Rx_Valid(b_rx_valid), .o_Rx_Parity_Err(b_pe),
    .o_Rx_Frame_Err(b_fe), .o_Rx_Busy(b_busy));

  int n_checks = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- TX model (instance B) ----------------
  logic [15:0] m_frame = 16'h0000;
  int          m_nbits = 11;
  int          m_pos = 0;
  logic        m_active = 1'b0;
  logic        m_ready = 1'b1;
  logic        m_pend = 1'b0;

  // ---------------- RX expectations (instance A) ----------------
  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rx_exp_t;
  rx_exp_t    exp_q[$];
  logic [7:0] last_d = 8'h00;
  logic       last_pe = 1'b0;
  logic       last_fe = 1'b0;

  // Model update on each rising edge, from the same inputs the DUT sees.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_active = 1'b0; m_pos = 0; m_ready = 1'b1; m_pend = 1'b0;
        last_d = 8'h00; last_pe = 1'b0; last_fe = 1'b0;
      end else if (m_active) begin
        m_pos++;
        if (m_pos == m_nbits * BD) begin
          m_active = 1'b0;
          m_pend = 1'b1;
        end
      end else if (m_pend) begin
        m_pend = 1'b0;
        m_ready = 1'b1;
      end else if (m_ready && b_tx_valid) begin
        m_frame = 16'h0000;
        m_frame[0] = 1'b0;
        for (int i = 0; i < 7; i++) m_frame[1+i] = b_tx_data[i];
        m_frame[8] = ($countones(b_tx_data) % 2) == 1;  // even: total weight even
        m_frame[9] = 1'b1;
        m_frame[10] = 1'b1;
        m_active = 1'b1;
        m_pos = 0;
        m_ready = 1'b0;
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("b_tx_serial", b_tx_serial, m_active ? m_frame[m_pos / BD] : 1'b1);
        check("b_tx_ready", b_tx_ready, m_ready);
        check("b_tx_active", b_tx_active, m_active);
        check("a_tx_idle", {a_tx_serial, a_tx_ready, a_tx_active}, 3'b110);
        check("b_rx_quiet", b_rx_valid, 1'b0);
        if (a_rx_valid) begin
          if (exp_q.size() == 0) begin
            check("rx_unexpected_valid", 1'b1, 1'b0);
          end else begin
            rx_exp_t e;
            e = exp_q.pop_front();
            last_d = e.d; last_pe = e.pe; last_fe = e.fe;
          end
        end
        check("a_rx_data", a_rx_data, last_d);
        check("a_rx_perr", a_pe, last_pe);
        check("a_rx_ferr", a_fe, last_fe);
      end
    end
  end

  task automatic drive_bit(input logic b);
    a_rx_serial = b;
    repeat (BD) @(negedge clk);
  endtask

  // Drive one odd-parity 8-bit frame into instance A and queue its result.
  task automatic send_rx(input logic [7:0] d, input logic p, input logic s);
    rx_exp_t e;
    e.d = d;
    e.pe = (($countones(d) + int'(p)) % 2) == 0;
    e.fe = ~s;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
    check("rx_valid_in_stop_bit", exp_q.size(), 0);
  endtask

  // Capture instance B's frame at bit centres, starting at the falling edge
  // right after acceptance, and measure cycles until ready returns.
  task automatic capture_tx(output logic [10:0] cap, output int rdy);
    cap = 11'h000;
    rdy = -1;
    for (int n = 0; n < 400; n++) begin
      if ((n % BD) == BD / 2 && n < 11 * BD) cap[n / BD] = b_tx_serial;
      if (b_tx_ready) begin
        rdy = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] cap;
    int rdy;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_tx_serial", b_tx_serial, 1'b1);
    check("rst_tx_ready", b_tx_ready, 1'b1);
    check("rst_tx_active", b_tx_active, 1'b0);
    check("rst_rx", {a_rx_data, a_rx_valid, a_pe, a_fe, a_busy}, 12'h000);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // TX 0x55, 7 bits, even parity, 2 stop
    b_tx_data = 7'h55;
    b_tx_valid = 1'b1;
    @(negedge clk);
    b_tx_valid = 1'b0;
    b_tx_data = 7'h00;
    capture_tx(cap, rdy);
    check("tx55_frame", cap, 11'h6AA);
    check("tx55_ready_latency", rdy, 177);
    repeat (5) @(negedge clk);

    // RX good frame and parity-error frame
    send_rx(8'hA5, 1'b1, 1'b1);
    a_rx_serial = 1'b1;
    repeat (20) @(negedge clk);
    check("rxA5_data", a_rx_data, 8'hA5);
    check("rxA5_flags", {a_pe, a_fe}, 2'b00);
    send_rx(8'h3C, 1'b0, 1'b1);
    a_rx_serial = 1'b1;
    repeat (20) @(negedge clk);
    check("rx3C_data", a_rx_data, 8'h3C);
    check("rx3C_flags", {a_pe, a_fe}, 2'b10);

    // Low stop bit, then hold low for 3 bit times
    send_rx(8'h0F, 1'b1, 1'b0);
    repeat (3 * BD) @(negedge clk);
    check("brk_ferr", a_fe, 1'b1);
    check("brk_data", a_rx_data, 8'h0F);
    check("brk_busy", a_busy, 1'b0);
    a_rx_serial = 1'b1;
    repeat (2 * BD) @(negedge clk);
    send_rx(8'h81, 1'b1, 1'b1);
    a_rx_serial = 1'b1;
    repeat (20) @(negedge clk);
    check("rx81_after_break", {a_rx_data, a_pe, a_fe}, 10'h204);

    // Glitch of OS/4 sample periods
    a_rx_serial = 1'b0;
    repeat ((OS / 4) * (CR / (BR * OS))) @(negedge clk);
    check("glitch_busy_high", a_busy, 1'b1);
    a_rx_serial = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy_low", a_busy, 1'b0);

    // Reset mid-DATA on TX with valid held high
    b_tx_data = 7'h12;
    b_tx_valid = 1'b1;
    repeat (40) @(negedge clk);
    reset = 1'b1;
    b_tx_data = 7'h3A;
    @(negedge clk);
    check("rst_mid_serial", b_tx_serial, 1'b1);
    check("rst_mid_active", b_tx_active, 1'b0);
    check("rst_mid_rx_data", a_rx_data, 8'h00);
    reset = 1'b0;
    @(negedge clk);
    b_tx_valid = 1'b0;
    capture_tx(cap, rdy);
    check("tx3A_frame", cap, 11'h674);
    check("tx3A_ready_latency", rdy, 177);
    repeat (10) @(negedge clk);

    check("rx_queue_drained", exp_q.size(), 0);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
